// File: rtl/cw_sequencer_if.sv
// ---------------------------------------------------------------------------
// cw_sequencer_if
// Bundles the control-word sequencer's bus into one interface.
//   Decoder/databus side : instr_in, cw_in, k_in, status_in, mem_ready
//   Sequencer side       : state, ir, status, k_out, applied control bits
//                          (alu_*, rf_*, ram_*, pc_*, status_ld), illegal
// modport slave  - the sequencer itself
// modport master - whatever feeds the sequencer and consumes its controls
// ---------------------------------------------------------------------------
interface cw_sequencer_if;
    logic [31:0] instr_in;
    logic [32:0] cw_in;
    logic [63:0] k_in;
    logic [4:0]  status_in;
    logic        mem_ready;

    logic [1:0]  state;
    logic [31:0] ir;
    logic [4:0]  status;
    logic [63:0] k_out;
    logic        alu_en;
    logic        alu_bs;
    logic [4:0]  alu_fs;
    logic        rf_b_en;
    logic [4:0]  rf_sa;
    logic [4:0]  rf_sb;
    logic [4:0]  rf_da;
    logic        rf_w;
    logic        ram_en;
    logic        ram_w;
    logic        pc_en;
    logic [1:0]  pc_fs;
    logic        pc_is;
    logic        status_ld;
    logic        illegal;

    modport slave (
        input  instr_in, cw_in, k_in, status_in, mem_ready,
        output state, ir, status, k_out,
        output alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
        output ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, illegal
    );

    modport master (
        output instr_in, cw_in, k_in, status_in, mem_ready,
        input  state, ir, status, k_out,
        input  alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
        input  ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, illegal
    );
endinterface

// File: rtl/cw_sequencer.sv
// ---------------------------------------------------------------------------
// cw_sequencer
// Four-state instruction sequencer (FETCH, EX0, EX1, EX2). In FETCH it drives
// a fixed fetch control word and latches the instruction when memory is
// ready; in the EX states it passes the decoder's control word straight
// through, gating the write-type fields with the advance condition.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - cw_sequencer_if.slave (decoder inputs, applied control outputs)
// ---------------------------------------------------------------------------
module cw_sequencer (
    input  logic          clock,
    input  logic          reset,
    cw_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EX0   = 2'b01,
        S_EX1   = 2'b10,
        S_EX2   = 2'b11
    } state_t;

    state_t      r_state;
    logic [31:0] r_ir;
    logic [4:0]  r_status;
    logic        r_illegal;

    state_t      w_next_state;
    logic        w_advance;
    logic        w_load_ir;
    logic        w_set_illegal;
    // Applied control word, same bit positions as cw_in (next_state excluded).
    logic [32:2] w_cw;

    // State register and the architectural registers it qualifies.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_status  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load_ir) begin
                r_ir <= bus.instr_in;
            end
            if (w_cw[2]) begin
                r_status <= bus.status_in;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state and applied control word.
    always_comb begin
        w_cw          = '0;
        w_advance     = 1'b0;
        w_next_state  = r_state;
        w_load_ir     = 1'b0;
        w_set_illegal = 1'b0;

        // Reset forces the fetch word so nothing writes while the machine
        // is being abandoned mid-instruction.
        if (reset || (r_state == S_FETCH)) begin
            w_cw[30:26] = 5'b11111;
            w_cw[24:10] = '1;
            w_cw[8]     = 1'b1;
            // ram_en is always 1 here, so advance reduces to mem_ready.
            w_advance   = bus.mem_ready;
            if (w_advance) begin
                w_cw[5:4]    = 2'b01;
                w_next_state = S_EX0;
                w_load_ir    = 1'b1;
            end
        end else begin
            w_cw      = bus.cw_in[32:2];
            w_advance = !bus.cw_in[8] || bus.mem_ready;
            if (!w_advance) begin
                w_cw[9]   = 1'b0;
                w_cw[7]   = 1'b0;
                w_cw[5:4] = 2'b00;
                w_cw[2]   = 1'b0;
            end else begin
                case (bus.cw_in[1:0])
                    2'b00: w_next_state = S_FETCH;
                    2'b01: w_next_state = S_EX1;
                    2'b10: w_next_state = S_EX2;
                    default: begin
                        w_next_state  = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
                // EX2 is the last execute cycle: only a return to FETCH is legal.
                if ((r_state == S_EX2) && (bus.cw_in[1:0] != 2'b00)) begin
                    w_next_state  = S_FETCH;
                    w_set_illegal = 1'b1;
                end
            end
        end
    end

    assign bus.state     = r_state;
    assign bus.ir        = r_ir;
    assign bus.status    = r_status;
    assign bus.illegal   = r_illegal;
    assign bus.k_out     = bus.k_in;

    assign bus.alu_en    = w_cw[32];
    assign bus.alu_bs    = w_cw[31];
    assign bus.alu_fs    = w_cw[30:26];
    assign bus.rf_b_en   = w_cw[25];
    assign bus.rf_sa     = w_cw[24:20];
    assign bus.rf_sb     = w_cw[19:15];
    assign bus.rf_da     = w_cw[14:10];
    assign bus.rf_w      = w_cw[9];
    assign bus.ram_en    = w_cw[8];
    assign bus.ram_w     = w_cw[7];
    assign bus.pc_en     = w_cw[6];
    assign bus.pc_fs     = w_cw[5:4];
    assign bus.pc_is     = w_cw[3];
    assign bus.status_ld = w_cw[2];

endmodule

// File: doc/cw_sequencer.md
CW_SEQUENCER -- requirements
Module: cw_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed as follows.
- clock  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-high reset.
- instr_in  input  32  instruction word from the databus, valid during FETCH.
- cw_in  input  33  control word from the instruction decoders for the current state.
- k_in  input  64  constant from the same decoder.
- status_in  input  5  ALU status flags.
- mem_ready  input  1  RAM access complete this cycle.
- state  output  2  current state: 00 FETCH, 01 EX0, 10 EX1, 11 EX2.
- ir  output  32  instruction register.
- status  output  5  registered status flags.
- k_out  output  64  equals k_in.
- alu_en, alu_bs, rf_b_en, ram_en, ram_w, pc_en, pc_is  output  1 each  control bits as applied.
- alu_fs  output  5  ALU function select.
- rf_sa, rf_sb, rf_da  output  5 each  register file addresses.
- rf_w  output  1  register file write enable.
- pc_fs  output  2  PC function select.
- status_ld  output  1  status load as applied.
- illegal  output  1  sticky flag for an illegal next_state value.

REQ-002 The cw_in field layout SHALL be as follows.
- [32] alu_en, [31] alu_bs, [30:26] alu_fs, [25] rf_b_en.
- [24:20] rf_sa, [19:15] rf_sb, [14:10] rf_da.
- [9] rf_w, [8] ram_en, [7] ram_w, [6] pc_en.
- [5:4] pc_fs, [3] pc_is, [2] status_ld, [1:0] next_state.

Function
REQ-003 advance SHALL be the internal signal defined as: (applied ram_en == 0) OR (mem_ready == 1).

REQ-004 In FETCH, the outputs SHALL be the fixed fetch word, regardless of cw_in.
- ram_en=1, ram_w=0.
- pc_fs=00 while waiting; pc_fs=01 (PC+4) in the advancing cycle.
- alu_fs=11111.
- All other control outputs 0.
- rf_sa, rf_sb, rf_da = 31.

REQ-005 In FETCH with advance=1, the block SHALL load ir <= instr_in and set state <= EX0 at the next edge.

REQ-006 In EX0, EX1 and EX2, the field outputs SHALL be driven combinationally from cw_in, with zero cycles of latency.

REQ-007 rf_w, ram_w, status_ld and pc_fs SHALL be gated by advance.
- When advance=0, rf_w=0, ram_w=0, status_ld=0 and pc_fs=00.
- All other fields SHALL hold their decoded value during a stall.

REQ-008 On advance in an EX state, the next state SHALL be selected by the next_state field of cw_in.
- 00 -> FETCH.
- 01 -> EX1.
- 10 -> EX2.
- 11 -> FETCH, and illegal <= 1.

REQ-009 In EX2, any next_state value other than 00 SHALL force FETCH and set illegal <= 1, limiting execution to 3 cycles.

REQ-010 When advance=0, state, ir and status SHALL hold their values.

REQ-011 When status_ld (as gated) = 1, the block SHALL load status <= status_in at the edge; otherwise status SHALL hold.

REQ-012 Once set, illegal SHALL remain 1 until reset.

REQ-013 ir SHALL change only on a FETCH advance.

Reset
REQ-014 At a clock edge with reset=1, the block SHALL set state=FETCH, ir=0, status=0 and illegal=0, with reset taking priority over every other update.

REQ-015 Reset asserted mid-stall or mid-EX SHALL abandon the instruction, and no write-enable output shall assert in the cycle after reset.

REQ-016 Outputs during the reset cycle SHALL follow the FETCH word of REQ-004.

Verification
REQ-017 A bench SHALL cover the following directed scenarios.
- Fetch with stall: reset, instr_in=0x94000003, mem_ready=0 for 2 cycles then 1 -> state stays 00 for 3 cycles; pc_fs=00 for 2 cycles then 01; ir=0x94000003 after the 3rd edge; state=01.
- Single-cycle execute: EX0 with cw_in next_state=00, rf_w=1, rf_da=30, ram_en=0 -> rf_w=1 and rf_da=30 for one cycle; state returns to 00.
- Multi-cycle load: EX0 next_state=01; EX1 with ram_en=1, rf_w=1, mem_ready low for 1 cycle, next_state=00 -> rf_w=0 during the stall, rf_w=1 in the ready cycle; sequence 01,10,10,00.
- Status load: EX0 with status_ld=1, status_in=5'b10110 -> status=10110 after the edge; a later EX with status_ld=0 and status_in=00001 leaves status=10110.
- Illegal next_state: EX0 with next_state=11 -> state 00, illegal=1 held through later instructions until reset clears it to 0.
- Reset mid-EX1: reset asserted in EX1 with rf_w=1, ram_w=1 -> next cycle state=00, ir=0, rf_w=0, ram_w=0, ram_en=1.
